// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage : decode stage of the 5-stage 16-bit pipeline.
//
// Decodes the instruction handed over by fetch, reads the 16x16 register
// file, resolves BEQ/JMP here (branch target back to fetch), detects the
// load-use and branch-operand hazards, and issues decoded operands into the
// ID/EX latch (ex_*). Instruction format: op[15:12] rd[11:8] rs[7:4] rt/imm4[3:0].
//
// Configuration macro: ID_WB_BYPASS_EN
//   defined   : a read of wb_rd while wb_wr_en sees wb_data in the same cycle
//   undefined : reads see the old value; a source equal to a pending
//               writeback register stalls for one cycle instead
//
// Ports
//   CLOCK_50          in   single clock, all flops on posedge
//   reset             in   asynchronous, active-low
//   id_instr          in   instruction from fetch
//   id_instr_addr     in   address of id_instr
//   wb_wr_en/rd/data  in   writeback port into the register file
//   mem_wr_en, mem_rd in   register write pending in the MEM stage
//   STALL             out  hold fetch (combinational)
//   BRANCH            out  redirect fetch (combinational)
//   branch_instr_addr out  redirect target
//   ex_valid          out  ID/EX latch holds a real instruction
//   ex_op, ex_rd      out  opcode, destination register
//   ex_a, ex_b        out  rs value; rt value (rd value for SW)
//   ex_imm            out  sign-extended imm4
//   ex_instr_addr     out  address of the issued instruction
// ----------------------------------------------------------------------------
// state     | meaning
// ST_RUN    | input instruction is on the correct path, decode normally
// ST_SQUASH | previous cycle branched; input is wrong-path, issue a bubble
// ----------------------------------------------------------------------------
module id_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [DATA_W-1:0] id_instr,
    input  logic [DATA_W-1:0] id_instr_addr,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              STALL,
    output logic              BRANCH,
    output logic [DATA_W-1:0] branch_instr_addr,
    output logic              ex_valid,
    output logic [3:0]        ex_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_instr_addr
);

    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;

    typedef enum logic {ST_RUN, ST_SQUASH} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] regs [2**REG_AW];

    logic [3:0]        op;
    logic [REG_AW-1:0] f_rd, f_rs, f_rt;
    logic [DATA_W-1:0] val_rd, val_rs, val_rt, imm_sext;
    logic              use_rs, use_rt, use_rd;
    logic              ex_writer, load_use, beq_haz, wb_haz, issue;

    assign op   = id_instr[15:12];
    assign f_rd = id_instr[11:8];
    assign f_rs = id_instr[7:4];
    assign f_rt = id_instr[3:0];
    assign imm_sext = {{(DATA_W-4){id_instr[3]}}, id_instr[3:0]};

    function automatic logic [DATA_W-1:0] read_port(
        input logic [REG_AW-1:0] a,
        input logic              we,
        input logic [REG_AW-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        v = stored;
`ifdef ID_WB_BYPASS_EN
        if (we && wa != '0 && wa == a) v = wd;
`else
        if (we && wa == a && 1'b0) v = wd;
`endif
        if (a == '0) v = '0;
        return v;
    endfunction

    assign val_rd = read_port(f_rd, wb_wr_en, wb_rd, wb_data, regs[f_rd]);
    assign val_rs = read_port(f_rs, wb_wr_en, wb_rd, wb_data, regs[f_rs]);
    assign val_rt = read_port(f_rt, wb_wr_en, wb_rd, wb_data, regs[f_rt]);

    // Source usage: ALU ops read rs,rt; ADDI/LW read rs; SW/BEQ read rd,rs.
    assign use_rs = (op <= OP_BEQ);
    assign use_rt = (op <= OP_OR);
    assign use_rd = (op == OP_SW) || (op == OP_BEQ);

    function automatic logic src_match(
        input logic [REG_AW-1:0] r,
        input logic              u_rs,
        input logic              u_rt,
        input logic              u_rd,
        input logic [REG_AW-1:0] a_rs,
        input logic [REG_AW-1:0] a_rt,
        input logic [REG_AW-1:0] a_rd
    );
        return (u_rs && a_rs == r) || (u_rt && a_rt == r) || (u_rd && a_rd == r);
    endfunction

    assign ex_writer = ex_valid && (ex_op <= OP_LW) && (ex_rd != '0);
    assign load_use  = ex_valid && (ex_op == OP_LW) &&
                       src_match(ex_rd, use_rs, use_rt, use_rd, f_rs, f_rt, f_rd);
    // BEQ compares in this stage, so it cannot use the EX/MEM forwarding paths.
    assign beq_haz   = (op == OP_BEQ) &&
                       ((ex_writer && src_match(ex_rd, use_rs, use_rt, use_rd, f_rs, f_rt, f_rd)) ||
                        (mem_wr_en && mem_rd != '0 &&
                         src_match(mem_rd, use_rs, use_rt, use_rd, f_rs, f_rt, f_rd)));
`ifdef ID_WB_BYPASS_EN
    assign wb_haz    = 1'b0;
`else
    assign wb_haz    = wb_wr_en && (wb_rd != '0) &&
                       src_match(wb_rd, use_rs, use_rt, use_rd, f_rs, f_rt, f_rd);
`endif

    assign branch_instr_addr = (op == OP_JMP) ?
                               {id_instr_addr[DATA_W-1:12], id_instr[11:0]} :
                               id_instr_addr + DATA_W'(1) + imm_sext;

    always_comb begin
        state_nxt = ST_RUN;
        STALL     = 1'b0;
        BRANCH    = 1'b0;
        issue     = 1'b0;
        // Gating on reset keeps the handshake outputs quiet while held in reset.
        if (reset && state == ST_RUN) begin
            STALL = load_use || beq_haz || wb_haz;
            if (!STALL) begin
                BRANCH = (op == OP_JMP) || (op == OP_BEQ && val_rd == val_rs);
                issue  = (op <= OP_SW);
            end
            if (BRANCH) state_nxt = ST_SQUASH;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else if (wb_wr_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            ex_valid      <= 1'b0;
            ex_op         <= '0;
            ex_rd         <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_imm        <= '0;
            ex_instr_addr <= '0;
        end else if (issue) begin
            ex_valid      <= 1'b1;
            ex_op         <= op;
            ex_rd         <= f_rd;
            ex_a          <= val_rs;
            ex_b          <= (op == OP_SW) ? val_rd : val_rt;
            ex_imm        <= imm_sext;
            ex_instr_addr <= id_instr_addr;
        end else begin
            ex_valid      <= 1'b0;
            ex_op         <= '0;
            ex_rd         <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_imm        <= '0;
            ex_instr_addr <= '0;
        end
    end

endmodule
